muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the execute stage.
- Consumes operand_A/operand_B as read from the register file.
- Returns result plus destination tag to the writeback path, which drives the register file's write_data, rd and write_enable.
- Radix-2, one result bit per cycle; the pipeline stalls on busy.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_sign_fix.sv | 35 +++
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int DEFAULT_BITWIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int cnt_width(input int bw);
    return $clog2(bw);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Turns the unsigned magnitude datapath result into the final RV32M result.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int bitwidth = DEFAULT_BITWIDTH
) (
  input  logic [2*bitwidth-1:0] mag,
  input  logic                  sign_a,
  input  logic                  sign_b,
  input  logic [2:0]            funct3,
  output logic [bitwidth-1:0]   result
);

  logic                  neg;
  logic [2*bitwidth-1:0] prod;
  logic [bitwidth-1:0]   quo;
  logic [bitwidth-1:0]   rem;

  // mag holds the product for multiplies and {remainder, quotient} for divides
  always_comb begin
    neg    = sign_a ^ sign_b;
    prod   = neg ? -mag : mag;
    quo    = mag[bitwidth-1:0];
    rem    = mag[2*bitwidth-1:bitwidth];
    result = '0;
    case (funct3)
      F3_MUL:                      result = mag[bitwidth-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result = prod[2*bitwidth-1:bitwidth];
      F3_DIV, F3_DIVU:             result = neg ? -quo : quo;
      F3_REM, F3_REMU:             result = sign_a ? -rem : rem;
      default:                     result = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit, one result bit per cycle.
// Define MULDIV_EARLY_OUT_EN to skip iteration for zero/div-by-zero/overflow operands.
//
// state   | meaning
// ST_IDLE | waiting for start
// ST_CALC | one shift-add or shift-subtract step per cycle
// ST_FIN  | sign correction; result and rd_out written
// ST_DONE | done pulse; accepts a new start exactly like ST_IDLE
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int bitwidth = DEFAULT_BITWIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                flush,
  input  logic [2:0]          funct3,
  input  logic [bitwidth-1:0] operand_A,
  input  logic [bitwidth-1:0] operand_B,
  input  logic [4:0]          rd_in,
  output logic                busy,
  output logic                done,
  output logic [bitwidth-1:0] result,
  output logic [4:0]          rd_out
);

  localparam int               CNT_W    = cnt_width(bitwidth);
  localparam int               BW2      = 2 * bitwidth;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(bitwidth - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BW2-1:0]      acc_q, acc_d;
  logic [bitwidth-1:0] opnd_q, opnd_d;
  logic [2:0]          f3_q, f3_d;
  logic [4:0]          rd_q, rd_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  logic [bitwidth-1:0] result_q, result_d;
  logic [4:0]          rd_out_q, rd_out_d;

  logic                accept, is_mul, a_signed, b_signed, a_neg, b_neg, b_zero;
  logic [bitwidth-1:0] a_mag, b_mag;
  logic [bitwidth:0]   add_sum, rem_shift, sub_diff;
  logic [BW2-1:0]      step_mul, step_div;
  logic [bitwidth-1:0] fixed_result;
`ifdef MULDIV_EARLY_OUT_EN
  logic                early_div0, early_ovf, early_mul0;
`endif

  always_comb begin
    accept   = start && !flush && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    is_mul   = !funct3[2];
    a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV)  || (funct3 == F3_REM);
    b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg    = a_signed && operand_A[bitwidth-1];
    b_neg    = b_signed && operand_B[bitwidth-1];
    a_mag    = a_neg ? -operand_A : operand_A;
    b_mag    = b_neg ? -operand_B : operand_B;
    b_zero   = (operand_B == '0);
`ifdef MULDIV_EARLY_OUT_EN
    early_div0 = !is_mul && b_zero;
    early_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                 (operand_A == {1'b1, {(bitwidth-1){1'b0}}}) && (&operand_B);
    early_mul0 = is_mul && ((operand_A == '0) || b_zero);
`endif
  end

  // acc_q is {hi, lo}: product shifts right for multiply, {rem, quo} shifts left for divide
  always_comb begin
    add_sum   = {1'b0, acc_q[BW2-1:bitwidth]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    step_mul  = {add_sum, acc_q[bitwidth-1:1]};
    rem_shift = acc_q[BW2-1:bitwidth-1];
    sub_diff  = rem_shift - {1'b0, opnd_q};
    step_div  = sub_diff[bitwidth] ? {acc_q[BW2-2:0], 1'b0}
                                   : {sub_diff[bitwidth-1:0], acc_q[bitwidth-2:0], 1'b1};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d  = ST_CALC;
          cnt_d    = '0;
          acc_d    = {{bitwidth{1'b0}}, (is_mul ? b_mag : a_mag)};
          opnd_d   = is_mul ? a_mag : b_mag;
          f3_d     = funct3;
          rd_d     = rd_in;
          sign_a_d = a_neg;
          // signed divide by zero must give -1, so cancel the quotient negation
          sign_b_d = b_neg || (!is_mul && b_zero && a_neg);
`ifdef MULDIV_EARLY_OUT_EN
          if (early_div0) begin
            state_d = ST_FIN;
            acc_d   = {a_mag, {bitwidth{1'b1}}};
          end else if (early_mul0) begin
            state_d = ST_FIN;
            acc_d   = '0;
          end else if (early_ovf) begin
            state_d = ST_FIN;
          end
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = f3_q[2] ? step_div : step_mul;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          result_d = fixed_result;
          rd_out_d = rd_q;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  muldiv_sign_fix #(.bitwidth(bitwidth)) u_sign_fix (
    .mag    (acc_q),
    .sign_a (sign_a_q),
    .sign_b (sign_b_q),
    .funct3 (f3_q),
    .result (fixed_result)
  );

  assign busy   = (state_q == ST_CALC) || (state_q == ST_FIN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases, random ops, flush, reset, back-to-back.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
  localparam int LAT = 34;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] operand_A = 32'h0;
  logic [31:0] operand_B = 32'h0;
  logic [4:0]  rd_in = 5'd0;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  muldiv_unit #(.bitwidth(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .flush     (flush),
    .funct3    (funct3),
    .operand_A (operand_A),
    .operand_B (operand_B),
    .rd_in     (rd_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sbv, sp;
    logic [63:0]        up;
    logic signed [31:0] q;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    model = 32'h0;
    case (f3)
      OP_MUL:    begin up = {32'h0, a} * {32'h0, b}; model = up[31:0]; end
      OP_MULH:   begin sp = sa * sbv; model = sp[63:32]; end
      OP_MULHSU: begin sp = sa * $signed({32'h0, b}); model = sp[63:32]; end
      OP_MULHU:  begin up = {32'h0, a} * {32'h0, b}; model = up[63:32]; end
      OP_DIV: begin
        if (b == 32'h0) model = 32'hFFFF_FFFF;
        else if (ovf) model = a;
        else begin q = $signed(a) / $signed(b); model = q; end
      end
      OP_DIVU: model = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 32'h0) model = a;
        else if (ovf) model = 32'h0;
        else begin q = $signed(a) % $signed(b); model = q; end
      end
      OP_REMU: model = (b == 32'h0) ? a : a % b;
      default: model = 32'h0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (EARLY) begin
      if (f3[2] && b == 32'h0) return 2;
      if ((f3 == OP_DIV || f3 == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      if (!f3[2] && (a == 32'h0 || b == 32'h0)) return 2;
    end
    return LAT;
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res);
    exp_t e;
    @(negedge clk);
    start = 1'b1; funct3 = f3; operand_A = a; operand_B = b; rd_in = rd;
    e.res = res; e.rd = rd;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cyc);
    lat = 0; busy_cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset result: got %h want 0", result); end
    n_checks++; if (rd_out !== 5'd0) begin n_fail++; $display("FAIL reset rd_out: got %0d want 0", rd_out); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    vec_t v[$];
    exp_t e;
    int   lat, bcyc, el;
    v.push_back({OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB});
    v.push_back({OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000});
    v.push_back({OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE});
    v.push_back({OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF});
    v.push_back({OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFD});
    v.push_back({OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF});
    v.push_back({OP_DIVU,   32'd100,       32'd7,         5'd11, 32'd14});
    v.push_back({OP_REMU,   32'd100,       32'd7,         5'd11, 32'd2});
    v.push_back({OP_DIV,    32'd42,        32'd0,         5'd7,  32'hFFFF_FFFF});
    v.push_back({OP_REM,    32'd42,        32'd0,         5'd8,  32'd42});
    v.push_back({OP_DIV,    32'hFFFF_FFF9, 32'd0,         5'd9,  32'hFFFF_FFFF});
    v.push_back({OP_REM,    32'hFFFF_FFF9, 32'd0,         5'd10, 32'hFFFF_FFF9});
    v.push_back({OP_DIVU,   32'h1234_5678, 32'd0,         5'd12, 32'hFFFF_FFFF});
    v.push_back({OP_REMU,   32'h1234_5678, 32'd0,         5'd13, 32'h1234_5678});
    v.push_back({OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000});
    v.push_back({OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0});
    v.push_back({OP_MUL,    32'h0,         32'h0001_2345, 5'd16, 32'h0});
    v.push_back({OP_MULH,   32'hFFFF_FFFF, 32'h0,         5'd17, 32'h0});
    foreach (v[i]) begin
      issue(v[i].f3, v[i].a, v[i].b, v[i].rd, v[i].res);
      wait_done(lat, bcyc);
      e  = sb.pop_front();
      el = exp_lat(v[i].f3, v[i].a, v[i].b);
      n_checks++; if (lat !== el) begin n_fail++; $display("FAIL dir%0d latency: got %0d want %0d", i, lat, el); end
      n_checks++; if (bcyc !== el - 1) begin n_fail++; $display("FAIL dir%0d busy cycles: got %0d want %0d", i, bcyc, el - 1); end
      n_checks++; if (result !== e.res) begin n_fail++; $display("FAIL dir%0d result: got %h want %h", i, result, e.res); end
      n_checks++; if (rd_out !== e.rd) begin n_fail++; $display("FAIL dir%0d rd_out: got %0d want %0d", i, rd_out, e.rd); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL dir%0d done pulse width: got %b want 0", i, done); end
    end
  endtask

  task automatic test_random();
    exp_t        e;
    int          lat, bcyc, el;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;
    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 5))
        0: b = 32'($urandom_range(0, 15));
        1: a = 32'($urandom_range(0, 300));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      issue(f3, a, b, rd, model(f3, a, b));
      wait_done(lat, bcyc);
      e  = sb.pop_front();
      el = exp_lat(f3, a, b);
      n_checks++; if (lat !== el) begin n_fail++; $display("FAIL rnd%0d latency: got %0d want %0d", i, lat, el); end
      n_checks++; if (result !== e.res) begin n_fail++; $display("FAIL rnd%0d f3=%0d a=%h b=%h result: got %h want %h", i, f3, a, b, result, e.res); end
      n_checks++; if (rd_out !== e.rd) begin n_fail++; $display("FAIL rnd%0d rd_out: got %0d want %0d", i, rd_out, e.rd); end
    end
  endtask

  task automatic test_flush();
    exp_t e;
    int   lat, bcyc, n_done;
    issue(OP_DIVU, 32'd100, 32'd7, 5'd11, 32'd14);
    wait_done(lat, bcyc);
    e = sb.pop_front();
    n_checks++; if (result !== e.res) begin n_fail++; $display("FAIL flush setup result: got %h want %h", result, e.res); end
    @(negedge clk);
    start = 1'b1; funct3 = OP_MUL; operand_A = 32'd3; operand_B = 32'd5; rd_in = 5'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush busy: got %b want 0", busy); end
    n_checks++; if (result !== 32'd14) begin n_fail++; $display("FAIL flush result held: got %h want %h", result, 32'd14); end
    n_checks++; if (rd_out !== 5'd11) begin n_fail++; $display("FAIL flush rd_out held: got %0d want 11", rd_out); end
    n_done = 0;
    repeat (40) begin @(negedge clk); if (done) n_done++; end
    n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL flush done pulses: got %0d want 0", n_done); end
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = OP_DIVU; operand_A = 32'd9; operand_B = 32'd3;
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start+flush accepted: busy got %b want 0", busy); end
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    int   lat, n_done;
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
      if (i == 5) begin
        start = 1'b1; funct3 = OP_DIVU; operand_A = 32'd9; operand_B = 32'd3; rd_in = 5'd4;
      end
      if (i == 12) start = 1'b0;
    end
    e = sb.pop_front();
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL busy-ignore latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (result !== e.res) begin n_fail++; $display("FAIL busy-ignore result: got %h want %h", result, e.res); end
    n_checks++; if (rd_out !== e.rd) begin n_fail++; $display("FAIL busy-ignore rd_out: got %0d want %0d", rd_out, e.rd); end
    n_done = 0;
    repeat (40) begin @(negedge clk); if (done || busy) n_done++; end
    n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL busy-ignore queued op: got %0d active cycles want 0", n_done); end
  endtask

  task automatic test_rst_mid();
    int n_done;
    @(negedge clk);
    start = 1'b1; funct3 = OP_DIVU; operand_A = 32'd100; operand_B = 32'd7; rd_in = 5'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid-reset busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid-reset done: got %b want 0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL mid-reset result: got %h want 0", result); end
    n_checks++; if (rd_out !== 5'd0) begin n_fail++; $display("FAIL mid-reset rd_out: got %0d want 0", rd_out); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (40) begin @(negedge clk); if (done) n_done++; end
    n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL mid-reset done after release: got %0d want 0", n_done); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat, bcyc;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFD);
    wait_done(lat, bcyc);
    e = sb.pop_front();
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL b2b first latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (result !== e.res) begin n_fail++; $display("FAIL b2b first result: got %h want %h", result, e.res); end
    start = 1'b1; funct3 = OP_REMU; operand_A = 32'd100; operand_B = 32'd7; rd_in = 5'd13;
    e.res = 32'd2; e.rd = 5'd13;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b done drop: got %b want 0", done); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b accepted busy: got %b want 1", busy); end
    n_checks++; if (result !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL b2b result hold: got %h want %h", result, 32'hFFFF_FFFD); end
    n_checks++; if (rd_out !== 5'd12) begin n_fail++; $display("FAIL b2b rd_out hold: got %0d want 12", rd_out); end
    wait_done(lat, bcyc);
    e = sb.pop_front();
    n_checks++; if (lat + 1 !== LAT) begin n_fail++; $display("FAIL b2b second latency: got %0d want %0d", lat + 1, LAT); end
    n_checks++; if (result !== e.res) begin n_fail++; $display("FAIL b2b second result: got %h want %h", result, e.res); end
    n_checks++; if (rd_out !== e.rd) begin n_fail++; $display("FAIL b2b second rd_out: got %0d want %0d", rd_out, e.rd); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_busy_ignore();
    test_rst_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
